// File: rtl/lstm_pkg.sv
// Shared constants and FSM encoding for the LSTM cell-state update stage.
// Fixed-point words are signed Q(WIDTH-FRAC).FRAC.
package lstm_pkg;

  localparam int WIDTH_DEF = 32;
  localparam int FRAC_DEF  = 24;

  localparam logic signed [31:0] SAT_MAX = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] SAT_MIN = 32'sh8000_0000;
  localparam logic signed [31:0] ONE_FXP = 32'sh0100_0000;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_MUL_F = 3'd1,
    S_MUL_I = 3'd2,
    S_ADD_C = 3'd3,
    S_MUL_O = 3'd4,
    S_DONE  = 3'd5
  } state_e;

endpackage

// File: rtl/fxp_mul_sat.sv
// Combinational signed fixed-point multiply: full product, floor shift
// by FRAC, then clamp to the WIDTH-bit signed range.
module fxp_mul_sat #(
  parameter int WIDTH = 32,
  parameter int FRAC  = 24
) (
  input  logic signed [WIDTH-1:0] a_i,
  input  logic signed [WIDTH-1:0] b_i,
  output logic signed [WIDTH-1:0] p_o
);

  localparam logic signed [WIDTH-1:0] MAXW =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINW =
    {1'b1, {(WIDTH-1){1'b0}}};

  logic signed [2*WIDTH-1:0] prod;
  logic signed [2*WIDTH-1:0] shf;

  always_comb begin
    prod = (2*WIDTH)'(a_i) * (2*WIDTH)'(b_i);
    shf  = prod >>> FRAC;
    if (shf > (2*WIDTH)'(MAXW))
      p_o = MAXW;
    else if (shf < (2*WIDTH)'(MINW))
      p_o = MINW;
    else
      p_o = shf[WIDTH-1:0];
  end

endmodule

// File: rtl/fxp_tanh.sv
// Combinational tanh on Q.24 input: 16-segment linear interpolation
// over |x| in [0,4), odd symmetry, held at tanh(4) beyond.
module fxp_tanh
  import lstm_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic signed [WIDTH-1:0] x_i,
  output logic signed [WIDTH-1:0] y_o
);

  localparam int F = FRAC_DEF;

  function automatic logic [24:0] lut(input logic [4:0] k);
    logic [24:0] v;
    v = '0;
    case (k)
      5'd0:  v = 25'd0;
      5'd1:  v = 25'd4109053;
      5'd2:  v = 25'd7753039;
      5'd3:  v = 25'd10656031;
      5'd4:  v = 25'd12777430;
      5'd5:  v = 25'd14231838;
      5'd6:  v = 25'd15185868;
      5'd7:  v = 25'd15793661;
      5'd8:  v = 25'd16173699;
      5'd9:  v = 25'd16408555;
      5'd10: v = 25'd16552641;
      5'd11: v = 25'd16639892;
      5'd12: v = 25'd16694249;
      5'd13: v = 25'd16726845;
      5'd14: v = 25'd16746646;
      5'd15: v = 25'd16758668;
      default: v = 25'd16765964;
    endcase
    return v;
  endfunction

  logic             neg;
  logic [WIDTH:0]   ax;
  logic             big;
  logic [3:0]       k;
  logic [F-3:0]     fr;
  logic [24:0]      lo;
  logic [24:0]      hi;
  logic [24:0]      mag;
  logic [WIDTH-1:0] m;

  always_comb begin
    neg = x_i[WIDTH-1];
    ax  = neg ? -{x_i[WIDTH-1], x_i} : {x_i[WIDTH-1], x_i};
    big = |ax[WIDTH:F+2];
    k   = ax[F+1:F-2];
    fr  = ax[F-3:0];
    lo  = lut({1'b0, k});
    hi  = lut(5'({1'b0, k}) + 5'd1);
    // segment width is 0.25, so the fraction carries F-2 bits
    mag = big ? lut(5'd16)
              : lo + 25'((47'(hi - lo) * 47'(fr)) >> (F - 2));
    m   = WIDTH'(mag);
    y_o = neg ? (~m + 1'b1) : m;
  end

endmodule

// File: rtl/lstm_state_update.sv
// LSTM cell/hidden update: c = f*c_prev + i*g, h = o*tanh(c), using one
// shared saturating multiplier; c_prev is kept internally across samples.
module lstm_state_update
  import lstm_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int FRAC  = FRAC_DEF
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_clr,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic signed [WIDTH-1:0] i_f,
  input  logic signed [WIDTH-1:0] i_i,
  input  logic signed [WIDTH-1:0] i_g,
  input  logic signed [WIDTH-1:0] i_o,
  output logic                    o_valid,
  output logic signed [WIDTH-1:0] o_c,
  output logic signed [WIDTH-1:0] o_h
);

  localparam logic signed [WIDTH-1:0] MAXW =
    {1'b0, {(WIDTH-1){1'b1}}};
  localparam logic signed [WIDTH-1:0] MINW =
    {1'b1, {(WIDTH-1){1'b0}}};

  state_e state_q;
  logic signed [WIDTH-1:0] f_q, i_q, g_q, og_q;
  logic signed [WIDTH-1:0] p0_q, p1_q, c_q, h_q;
  logic                    clr_q, valid_q, ready_q;

  logic signed [WIDTH-1:0] mul_a, mul_b, mul_p;
  logic signed [WIDTH-1:0] tanh_c;
  logic signed [WIDTH:0]   sum;
  logic signed [WIDTH-1:0] c_d;

  fxp_mul_sat #(.WIDTH(WIDTH), .FRAC(FRAC)) u_mul (
    .a_i (mul_a),
    .b_i (mul_b),
    .p_o (mul_p)
  );

  fxp_tanh #(.WIDTH(WIDTH)) u_tanh (
    .x_i (c_q),
    .y_o (tanh_c)
  );

  // c_q doubles as c_prev; a pending clear masks it without touching o_c
  always_comb begin
    mul_a = '0;
    mul_b = '0;
    unique case (state_q)
      S_MUL_F: begin
        mul_a = f_q;
        mul_b = clr_q ? '0 : c_q;
      end
      S_MUL_I: begin
        mul_a = i_q;
        mul_b = g_q;
      end
      S_MUL_O: begin
        mul_a = og_q;
        mul_b = tanh_c;
      end
      default: ;
    endcase
  end

  always_comb begin
    sum = {p0_q[WIDTH-1], p0_q} + {p1_q[WIDTH-1], p1_q};
    if (sum[WIDTH] != sum[WIDTH-1])
      c_d = sum[WIDTH] ? MINW : MAXW;
    else
      c_d = sum[WIDTH-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      f_q     <= '0;
      i_q     <= '0;
      g_q     <= '0;
      og_q    <= '0;
      p0_q    <= '0;
      p1_q    <= '0;
      c_q     <= '0;
      h_q     <= '0;
      clr_q   <= 1'b0;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (i_valid && ready_q) begin
            f_q     <= i_f;
            i_q     <= i_i;
            g_q     <= i_g;
            og_q    <= i_o;
            clr_q   <= i_clr;
            ready_q <= 1'b0;
            state_q <= S_MUL_F;
          end
        end
        S_MUL_F: begin
          p0_q    <= mul_p;
          state_q <= S_MUL_I;
        end
        S_MUL_I: begin
          p1_q    <= mul_p;
          state_q <= S_ADD_C;
        end
        S_ADD_C: begin
          c_q     <= c_d;
          clr_q   <= 1'b0;
          state_q <= S_MUL_O;
        end
        S_MUL_O: begin
          h_q     <= mul_p;
          valid_q <= 1'b1;
          state_q <= S_DONE;
        end
        S_DONE: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          valid_q <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready = ready_q;
  assign o_valid = valid_q;
  assign o_c     = c_q;
  assign o_h     = h_q;

endmodule
